// File: rtl/nvdla_dbb_mem_bridge.sv
// Bridge from the NVDLA DBB split-channel master port to a single-port TCDM-style memory.
// Write beats pass straight through. Read data returns through a credit-limited FIFO.
module nvdla_dbb_mem_bridge #(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned ID_WIDTH      = 8,
  parameter int unsigned LEN_WIDTH     = 4,
  parameter int unsigned RD_FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    wr_req_valid_i,
  output logic                    wr_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   wr_req_addr_i,
  input  logic [LEN_WIDTH-1:0]    wr_req_len_i,
  input  logic [ID_WIDTH-1:0]     wr_req_id_i,
  input  logic                    rd_req_valid_i,
  output logic                    rd_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   rd_req_addr_i,
  input  logic [LEN_WIDTH-1:0]    rd_req_len_i,
  input  logic [ID_WIDTH-1:0]     rd_req_id_i,
  input  logic                    wdat_valid_i,
  output logic                    wdat_ready_o,
  input  logic [DATA_WIDTH-1:0]   wdat_data_i,
  input  logic [DATA_WIDTH/8-1:0] wdat_strb_i,
  input  logic                    wdat_last_i,
  output logic                    wrsp_valid_o,
  input  logic                    wrsp_ready_i,
  output logic [ID_WIDTH-1:0]     wrsp_id_o,
  output logic                    rdat_valid_o,
  input  logic                    rdat_ready_i,
  output logic [DATA_WIDTH-1:0]   rdat_data_o,
  output logic                    rdat_last_o,
  output logic [ID_WIDTH-1:0]     rdat_id_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic                    mem_wen_o,
  output logic [ADDR_WIDTH-1:0]   mem_add_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_data_o,
  input  logic                    mem_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   mem_r_data_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned PW    = $clog2(RD_FIFO_DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned SW    = CW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRITE_RESP, S_READ} state_t;

  state_t                state_q, state_d;
  logic                  prio_rd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [LEN_WIDTH-1:0]  beat_cnt_q;
  logic                  err_q;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic                  drain_q;

  logic [ID_WIDTH-1:0]   tag_id_q   [RD_FIFO_DEPTH];
  logic                  tag_last_q [RD_FIFO_DEPTH];
  logic [PW-1:0]         tag_wptr_q, tag_rptr_q;

  logic [DATA_WIDTH-1:0] rf_data_q  [RD_FIFO_DEPTH];
  logic [ID_WIDTH-1:0]   rf_id_q    [RD_FIFO_DEPTH];
  logic                  rf_last_q  [RD_FIFO_DEPTH];
  logic [PW-1:0]         rf_wptr_q, rf_rptr_q;
  logic [CW-1:0]         rf_count_q;

  logic                  wr_win, rd_win, wr_acc, rd_acc;
  logic                  final_beat, grant, wr_grant, rd_grant;
  logic                  credit_ok, ret_push, rf_pop;
  logic [SW-1:0]         credit_sum;
  logic [ADDR_WIDTH-1:0] beat_addr;

  // Each request ready depends only on the FSM state, the priority bit and the valids.
  assign wr_win         = wr_req_valid_i && (!rd_req_valid_i || !prio_rd_q);
  assign rd_win         = rd_req_valid_i && (!wr_req_valid_i ||  prio_rd_q);
  assign wr_req_ready_o = (state_q == S_IDLE) && wr_win;
  assign rd_req_ready_o = (state_q == S_IDLE) && rd_win;
  assign wr_acc         = wr_req_valid_i && wr_req_ready_o;
  assign rd_acc         = rd_req_valid_i && rd_req_ready_o;

  assign final_beat = (beat_cnt_q == len_q);
  assign beat_addr  = addr_q + (ADDR_WIDTH'(beat_cnt_q) * ADDR_WIDTH'(BYTES));
  assign credit_sum = {1'b0, rf_count_q} + {1'b0, inflight_q};
  assign credit_ok  = !drain_q && (credit_sum < SW'(RD_FIFO_DEPTH));

  assign grant    = mem_req_o && mem_gnt_i;
  assign wr_grant = (state_q == S_WRITE) && grant;
  assign rd_grant = (state_q == S_READ) && grant;

  assign ret_push = mem_r_valid_i && (inflight_q != '0) && !drain_q;
  assign rf_pop   = rdat_valid_o && rdat_ready_i;

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_wen_o    = 1'b0;
    mem_add_o    = '0;
    mem_be_o     = '0;
    mem_data_o   = '0;
    wdat_ready_o = 1'b0;
    wrsp_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_acc)      state_d = S_WRITE;
        else if (rd_acc) state_d = S_READ;
      end
      S_WRITE: begin
        mem_req_o    = wdat_valid_i;
        mem_add_o    = beat_addr;
        mem_be_o     = wdat_strb_i;
        mem_data_o   = wdat_data_i;
        wdat_ready_o = mem_gnt_i;
        if (wdat_valid_i && mem_gnt_i && final_beat) state_d = S_WRITE_RESP;
      end
      S_WRITE_RESP: begin
        wrsp_valid_o = 1'b1;
        if (wrsp_ready_i) state_d = S_IDLE;
      end
      S_READ: begin
        mem_req_o = credit_ok;
        mem_wen_o = 1'b1;
        mem_add_o = beat_addr;
        mem_be_o  = '1;
        if (credit_ok && mem_gnt_i && final_beat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (rd_grant) inflight_d = inflight_d + CW'(1);
    if (mem_r_valid_i && (inflight_q != '0)) inflight_d = inflight_d - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= S_IDLE;
      prio_rd_q  <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      id_q       <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      tag_wptr_q <= '0;
      tag_rptr_q <= '0;
      rf_wptr_q  <= '0;
      rf_rptr_q  <= '0;
      rf_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (wr_acc || rd_acc) begin
        prio_rd_q  <= ~prio_rd_q;
        addr_q     <= wr_acc ? wr_req_addr_i : rd_req_addr_i;
        len_q      <= wr_acc ? wr_req_len_i  : rd_req_len_i;
        id_q       <= wr_acc ? wr_req_id_i   : rd_req_id_i;
        beat_cnt_q <= '0;
      end else if (grant) begin
        beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
      end
      if (wr_grant && (wdat_last_i != final_beat)) err_q <= 1'b1;
      if (rd_grant) tag_wptr_q <= tag_wptr_q + PW'(1);
      if (ret_push) begin
        tag_rptr_q <= tag_rptr_q + PW'(1);
        rf_wptr_q  <= rf_wptr_q + PW'(1);
      end
      if (rf_pop) rf_rptr_q <= rf_rptr_q + PW'(1);
      case ({ret_push, rf_pop})
        2'b10:   rf_count_q <= rf_count_q + CW'(1);
        2'b01:   rf_count_q <= rf_count_q - CW'(1);
        default: rf_count_q <= rf_count_q;
      endcase
    end
  end

  // inflight survives a soft clear so returns that were already issued can be
  // discarded; drain_q blocks new issue until the last of them has arrived.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      drain_q    <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      if (clear_i)                 drain_q <= (inflight_d != '0);
      else if (inflight_d == '0)   drain_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_grant) begin
      tag_id_q[tag_wptr_q]   <= id_q;
      tag_last_q[tag_wptr_q] <= final_beat;
    end
    if (ret_push) begin
      rf_data_q[rf_wptr_q] <= mem_r_data_i;
      rf_id_q[rf_wptr_q]   <= tag_id_q[tag_rptr_q];
      rf_last_q[rf_wptr_q] <= tag_last_q[tag_rptr_q];
    end
  end

  assign rdat_valid_o = (rf_count_q != '0);
  assign rdat_data_o  = rdat_valid_o ? rf_data_q[rf_rptr_q] : '0;
  assign rdat_id_o    = rdat_valid_o ? rf_id_q[rf_rptr_q]   : '0;
  assign rdat_last_o  = rdat_valid_o && rf_last_q[rf_rptr_q];

  assign wrsp_id_o = id_q;
  assign busy_o    = (state_q != S_IDLE) || rdat_valid_o;
  assign err_o     = err_q;

endmodule

// File: tb/tb_nvdla_dbb_mem_bridge.sv
// Directed bench for nvdla_dbb_mem_bridge with a fixed-latency in-order memory model.
module tb_nvdla_dbb_mem_bridge;
  localparam int DW = 512;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1, clear_i = 1'b0;
  logic          wr_req_valid_i = 1'b0, wr_req_ready_o;
  logic [AW-1:0] wr_req_addr_i = '0;
  logic [LW-1:0] wr_req_len_i = '0;
  logic [IW-1:0] wr_req_id_i = '0;
  logic          rd_req_valid_i = 1'b0, rd_req_ready_o;
  logic [AW-1:0] rd_req_addr_i = '0;
  logic [LW-1:0] rd_req_len_i = '0;
  logic [IW-1:0] rd_req_id_i = '0;
  logic          wdat_valid_i = 1'b0, wdat_ready_o;
  logic [DW-1:0] wdat_data_i = '0;
  logic [DW/8-1:0] wdat_strb_i = '0;
  logic          wdat_last_i = 1'b0;
  logic          wrsp_valid_o, wrsp_ready_i = 1'b1;
  logic [IW-1:0] wrsp_id_o;
  logic          rdat_valid_o, rdat_ready_i = 1'b1;
  logic [DW-1:0] rdat_data_o;
  logic          rdat_last_o;
  logic [IW-1:0] rdat_id_o;
  logic          mem_req_o, mem_gnt_i = 1'b1, mem_wen_o;
  logic [AW-1:0] mem_add_o;
  logic [DW/8-1:0] mem_be_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_r_valid_i = 1'b0;
  logic [DW-1:0] mem_r_data_i = '0;
  logic          busy_o, err_o;

  nvdla_dbb_mem_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW), .RD_FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o),
    .wr_req_addr_i(wr_req_addr_i), .wr_req_len_i(wr_req_len_i), .wr_req_id_i(wr_req_id_i),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
    .rd_req_addr_i(rd_req_addr_i), .rd_req_len_i(rd_req_len_i), .rd_req_id_i(rd_req_id_i),
    .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_data_i(wdat_data_i),
    .wdat_strb_i(wdat_strb_i), .wdat_last_i(wdat_last_i),
    .wrsp_valid_o(wrsp_valid_o), .wrsp_ready_i(wrsp_ready_i), .wrsp_id_o(wrsp_id_o),
    .rdat_valid_o(rdat_valid_o), .rdat_ready_i(rdat_ready_i), .rdat_data_o(rdat_data_o),
    .rdat_last_o(rdat_last_o), .rdat_id_o(rdat_id_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_wen_o(mem_wen_o),
    .mem_add_o(mem_add_o), .mem_be_o(mem_be_o), .mem_data_o(mem_data_o),
    .mem_r_valid_i(mem_r_valid_i), .mem_r_data_i(mem_r_data_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Memory model: in-order read returns `lat` cycles after each read grant.
  typedef struct { int due; logic [31:0] addr; } ret_t;
  ret_t        rq[$];
  int          cyc_n = 0;
  int          lat = 1;
  int          rd_grants = 0;
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [40:0] rd_beats[$];

  always @(posedge clk) begin
    cyc_n++;
    if (mem_req_o && mem_gnt_i) begin
      if (mem_wen_o) begin
        rd_grants++;
        rq.push_back('{cyc_n + lat, mem_add_o});
      end else begin
        wr_addr_log.push_back(mem_add_o);
        wr_data_log.push_back(mem_data_o[31:0]);
      end
    end
    if (rdat_valid_o && rdat_ready_i)
      rd_beats.push_back({rdat_last_o, rdat_id_o, rdat_data_o[31:0]});
    #1;
    if (rq.size() > 0 && rq[0].due <= cyc_n + 1) begin
      mem_r_valid_i = 1'b1;
      mem_r_data_i  = {16{rq[0].addr}};
      void'(rq.pop_front());
    end else begin
      mem_r_valid_i = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len,
                          input logic [7:0] id, input int bad);
    int n;
    logic [31:0] a;
    wr_req_addr_i = addr; wr_req_len_i = len; wr_req_id_i = id; wr_req_valid_i = 1'b1;
    #1;
    n = 0;
    while (!wr_req_ready_o && n < 50) begin tick(); #1; n++; end
    check("wr_accept", wr_req_ready_o, 1'b1);
    tick();
    wr_req_valid_i = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 32'(i * 64);
      wdat_valid_i = 1'b1;
      wdat_data_i  = {16{a}};
      wdat_strb_i  = '1;
      wdat_last_i  = (i == int'(len)) ^ (i == bad);
      #1;
      n = 0;
      while (!wdat_ready_o && n < 50) begin tick(); #1; n++; end
      check("wdat_ready", wdat_ready_o, 1'b1);
      tick();
    end
    wdat_valid_i = 1'b0;
    wdat_last_i  = 1'b0;
    check("wrsp_valid", wrsp_valid_o, 1'b1);
    check("wrsp_id", wrsp_id_o, id);
    tick();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id);
    int n;
    rd_req_addr_i = addr; rd_req_len_i = len; rd_req_id_i = id; rd_req_valid_i = 1'b1;
    #1;
    n = 0;
    while (!rd_req_ready_o && n < 50) begin tick(); #1; n++; end
    check("rd_accept", rd_req_ready_o, 1'b1);
    tick();
    rd_req_valid_i = 1'b0;
  endtask

  task automatic wait_beats(input int base, input int n);
    int k = 0;
    while (rd_beats.size() - base < n && k < 200) begin tick(); k++; end
    check("rd_beat_count", rd_beats.size() - base, n);
  endtask

  initial begin
    int wb, rb, g0;
    logic [31:0] exp_a;

    // Reset state
    tick(); tick(); tick();
    rst_i = 1'b0;
    #1;
    check("rst_wr_ready", wr_req_ready_o, 1'b0);
    check("rst_rd_ready", rd_req_ready_o, 1'b0);
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_wrsp_valid", wrsp_valid_o, 1'b0);
    check("rst_rdat_valid", rdat_valid_o, 1'b0);
    tick();

    // Single write: 4 beats at 64-byte stride
    wb = wr_addr_log.size();
    do_write(32'h1000, 4'd3, 8'h5A, -1);
    check("w1_beats", wr_addr_log.size() - wb, 4);
    for (int i = 0; i < 4; i++) begin
      exp_a = 32'h1000 + 32'(i * 64);
      check("w1_addr", wr_addr_log[wb + i], exp_a);
      check("w1_data", wr_data_log[wb + i], exp_a);
    end
    check("w1_err", err_o, 1'b0);
    check("w1_busy", busy_o, 1'b0);

    // Wrap and burst-length error
    wb = wr_addr_log.size();
    do_write(32'hFFFF_FFC0, 4'd1, 8'h77, 0);
    check("wrap_beats", wr_addr_log.size() - wb, 2);
    check("wrap_addr0", wr_addr_log[wb], 32'hFFFF_FFC0);
    check("wrap_addr1", wr_addr_log[wb + 1], 32'h0000_0000);
    check("err_set", err_o, 1'b1);
    tick();

    // Arbitration: write, read, write, read
    rb = rd_beats.size();
    rd_req_addr_i = 32'h5000; rd_req_len_i = 4'd0; rd_req_id_i = 8'h02; rd_req_valid_i = 1'b1;
    wr_req_addr_i = 32'h6000; wr_req_len_i = 4'd0; wr_req_id_i = 8'h01; wr_req_valid_i = 1'b1;
    #1;
    check("arb1_wr_ready", wr_req_ready_o, 1'b1);
    check("arb1_rd_ready", rd_req_ready_o, 1'b0);
    do_write(32'h6000, 4'd0, 8'h01, -1);
    wr_req_addr_i = 32'h7000; wr_req_id_i = 8'h03; wr_req_valid_i = 1'b1;
    #1;
    check("arb2_rd_ready", rd_req_ready_o, 1'b1);
    check("arb2_wr_ready", wr_req_ready_o, 1'b0);
    do_read(32'h5000, 4'd0, 8'h02);
    rd_req_addr_i = 32'h5100; rd_req_id_i = 8'h04; rd_req_valid_i = 1'b1;
    tick();
    #1;
    check("arb3_wr_ready", wr_req_ready_o, 1'b1);
    check("arb3_rd_ready", rd_req_ready_o, 1'b0);
    do_write(32'h7000, 4'd0, 8'h03, -1);
    do_read(32'h5100, 4'd0, 8'h04);
    wait_beats(rb, 2);
    check("arb_rd0", rd_beats[rb], {1'b1, 8'h02, 32'h5000});
    check("arb_rd1", rd_beats[rb + 1], {1'b1, 8'h04, 32'h5100});
    check("err_sticky", err_o, 1'b1);
    tick();

    // Read backpressure: credit limits issue to the FIFO depth
    rdat_ready_i = 1'b0;
    g0 = rd_grants;
    rb = rd_beats.size();
    do_read(32'h2000, 4'd7, 8'h11);
    for (int i = 0; i < 10; i++) tick();
    check("bp_grants", rd_grants - g0, 4);
    #1;
    check("bp_stall", mem_req_o, 1'b0);
    rdat_ready_i = 1'b1;
    wait_beats(rb, 8);
    for (int i = 0; i < 8; i++) begin
      exp_a = 32'h2000 + 32'(i * 64);
      check("bp_beat", rd_beats[rb + i], {(i == 7), 8'h11, exp_a});
    end
    tick(); tick();
    check("bp_idle", busy_o, 1'b0);

    // Clear with two reads in flight
    lat = 3;
    rb = rd_beats.size();
    do_read(32'h3000, 4'd7, 8'h22);
    tick(); tick();
    clear_i = 1'b1;
    mem_gnt_i = 1'b0;
    tick();
    clear_i = 1'b0;
    mem_gnt_i = 1'b1;
    check("clr_busy", busy_o, 1'b0);
    check("clr_err", err_o, 1'b0);
    do_read(32'h4000, 4'd0, 8'h33);
    #1;
    check("clr_drain_block", mem_req_o, 1'b0);
    wait_beats(rb, 1);
    for (int i = 0; i < 6; i++) tick();
    check("clr_only_one", rd_beats.size() - rb, 1);
    check("clr_beat", rd_beats[rb], {1'b1, 8'h33, 32'h4000});
    lat = 1;

    // Reset in the middle of a write burst
    wr_req_addr_i = 32'h8000; wr_req_len_i = 4'd3; wr_req_id_i = 8'h44; wr_req_valid_i = 1'b1;
    tick();
    wr_req_valid_i = 1'b0;
    wdat_valid_i = 1'b1; wdat_data_i = '0; wdat_strb_i = '1; wdat_last_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mrst_mem_req", mem_req_o, 1'b0);
    check("mrst_wdat_ready", wdat_ready_o, 1'b0);
    check("mrst_wrsp_valid", wrsp_valid_o, 1'b0);
    check("mrst_rdat_valid", rdat_valid_o, 1'b0);
    check("mrst_busy", busy_o, 1'b0);
    wdat_valid_i = 1'b0;
    wr_req_valid_i = 1'b1;
    #1;
    check("mrst_idle_ready", wr_req_ready_o, 1'b1);
    do_write(32'h9000, 4'd0, 8'h55, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
